// File: rtl/alu_execute_unit.sv
`timescale 1ns/1ps
// alu_execute_unit
//   Execute stage behind the arithmetic opcode decoder. Latches operands on an
//   accepted start, runs ADD/SUB in one cycle and MUL/DIV iteratively
//   (shift-add, restoring division), then pulses done/wr_en for one cycle.
//   Build option: define ALU_FAST_MUL_EN to replace the iterative multiplier
//   with a single-cycle combinational multiplier (MUL then takes the ADDSUB path).
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   start                 launch request, sampled only while idle
//   alu_sel               000 ADD, 001 SUB, 010 MUL, 011 DIV, 1xx illegal
//   alu_b_sel             operand B: 00 zero, 01 reg_b, 10 reg_c, 11 reg_d
//   destination_reg_flag  one-hot write target {D,C,B,A}
//   reg_a..reg_d          register file read values
//   result, result_hi     low result / product high byte or remainder
//   busy, done            handshake (done is a one-cycle pulse)
//   wr_en                 latched destination, valid with done only
//   flag_*                zero, carry/borrow, divide-by-zero, illegal opcode
module alu_execute_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_sel,
  input  logic [1:0]       alu_b_sel,
  input  logic [3:0]       destination_reg_flag,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [WIDTH-1:0] reg_b,
  input  logic [WIDTH-1:0] reg_c,
  input  logic [WIDTH-1:0] reg_d,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             busy,
  output logic             done,
  output logic [3:0]       wr_en,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_dz,
  output logic             flag_illegal
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDSUB = 3'd1;
  localparam logic [2:0] S_MUL    = 3'd2;
  localparam logic [2:0] S_DIV    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int CW = $clog2(WIDTH + 1);

  logic [2:0]         r_state;
  logic [WIDTH-1:0]   r_op_a, r_op_b;
  logic [2:0]         r_sel;
  logic [3:0]         r_dest;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_result, r_hi;
  logic               r_busy, r_done, r_zero, r_carry, r_dz, r_ill;
  logic [3:0]         r_wr_en;

  logic [WIDTH-1:0]   w_b_mux;
  logic [WIDTH:0]     w_sum, w_diff;
  logic [WIDTH:0]     w_div_sh;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_div_next;
  logic               w_fin, w_fin_carry, w_fin_dz, w_fin_ill;
  logic [WIDTH-1:0]   w_fin_res, w_fin_hi;

  always_comb begin
    case (alu_b_sel)
      2'b01:   w_b_mux = reg_b;
      2'b10:   w_b_mux = reg_c;
      2'b11:   w_b_mux = reg_d;
      default: w_b_mux = '0;
    endcase
  end

  // Top bit of the difference is the borrow (A < B).
  assign w_sum  = {1'b0, r_op_a} + {1'b0, r_op_b};
  assign w_diff = {1'b0, r_op_a} - {1'b0, r_op_b};

`ifdef ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_prod;
  assign w_prod = {{WIDTH{1'b0}}, r_op_a} * {{WIDTH{1'b0}}, r_op_b};
`else
  // Shift-add: r_acc = {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     w_mul_part;
  logic [2*WIDTH-1:0] w_mul_next;
  assign w_mul_part = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_op_a} : '0);
  assign w_mul_next = {w_mul_part, r_acc[WIDTH-1:1]};
`endif

  // Restoring division: r_acc = {remainder, dividend/quotient bits}.
  // The remainder always stays below the divisor, so the W-bit subtraction is exact.
  assign w_div_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ge   = (w_div_sh >= {1'b0, r_op_b});
  assign w_div_rem  = w_div_ge ? (w_div_sh[WIDTH-1:0] - r_op_b) : w_div_sh[WIDTH-1:0];
  assign w_div_next = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

  // Final values written on the edge that enters DONE.
  always_comb begin
    w_fin       = 1'b0;
    w_fin_res   = '0;
    w_fin_hi    = '0;
    w_fin_carry = 1'b0;
    w_fin_dz    = 1'b0;
    w_fin_ill   = 1'b0;
    case (r_state)
      S_ADDSUB: begin
        w_fin = 1'b1;
        if (r_sel[2]) begin
          w_fin_ill = 1'b1;
        end else begin
          case (r_sel[1:0])
            2'b01: begin
              w_fin_res   = w_diff[WIDTH-1:0];
              w_fin_carry = w_diff[WIDTH];
            end
`ifdef ALU_FAST_MUL_EN
            2'b10: begin
              w_fin_res   = w_prod[WIDTH-1:0];
              w_fin_hi    = w_prod[2*WIDTH-1:WIDTH];
              w_fin_carry = |w_prod[2*WIDTH-1:WIDTH];
            end
`endif
            default: begin
              w_fin_res   = w_sum[WIDTH-1:0];
              w_fin_carry = w_sum[WIDTH];
            end
          endcase
        end
      end
      S_MUL: begin
        if (r_cnt == '0) begin
          w_fin       = 1'b1;
          w_fin_res   = r_acc[WIDTH-1:0];
          w_fin_hi    = r_acc[2*WIDTH-1:WIDTH];
          w_fin_carry = |r_acc[2*WIDTH-1:WIDTH];
        end
      end
      S_DIV: begin
        if (r_cnt == '0) begin
          w_fin = 1'b1;
          if (r_op_b == '0) begin
            w_fin_res = '1;
            w_fin_hi  = r_op_a;
            w_fin_dz  = 1'b1;
          end else begin
            w_fin_res = r_acc[WIDTH-1:0];
            w_fin_hi  = r_acc[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_sel    <= '0;
      r_dest   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_hi     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_en  <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_dz     <= 1'b0;
      r_ill    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op_a   <= reg_a;
            r_op_b   <= w_b_mux;
            r_sel    <= alu_sel;
            r_dest   <= destination_reg_flag;
            r_busy   <= 1'b1;
            r_result <= '0;
            r_hi     <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_dz     <= 1'b0;
            r_ill    <= 1'b0;
            case (alu_sel)
              3'b010: begin
`ifdef ALU_FAST_MUL_EN
                r_state <= S_ADDSUB;
`else
                r_state <= S_MUL;
                r_acc   <= {{WIDTH{1'b0}}, w_b_mux};
                r_cnt   <= CW'(WIDTH);
`endif
              end
              3'b011: begin
                // A zero divisor skips the iterations and resolves on the next edge.
                r_state <= S_DIV;
                r_acc   <= {{WIDTH{1'b0}}, reg_a};
                r_cnt   <= (w_b_mux == '0) ? '0 : CW'(WIDTH);
              end
              default: r_state <= S_ADDSUB;
            endcase
          end
        end
`ifndef ALU_FAST_MUL_EN
        S_MUL: begin
          if (r_cnt != '0) begin
            r_acc <= w_mul_next;
            r_cnt <= r_cnt - CW'(1);
          end
        end
`endif
        S_DIV: begin
          if (r_cnt != '0) begin
            r_acc <= w_div_next;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_wr_en <= '0;
          r_state <= S_IDLE;
        end
        default: ;
      endcase

      if (w_fin) begin
        r_result <= w_fin_res;
        r_hi     <= w_fin_hi;
        r_zero   <= (w_fin_res == '0);
        r_carry  <= w_fin_carry;
        r_dz     <= w_fin_dz;
        r_ill    <= w_fin_ill;
        r_done   <= 1'b1;
        r_wr_en  <= w_fin_ill ? 4'b0000 : r_dest;
        r_busy   <= 1'b0;
        r_state  <= S_DONE;
      end
    end
  end

  assign result       = r_result;
  assign result_hi    = r_hi;
  assign busy         = r_busy;
  assign done         = r_done;
  assign wr_en        = r_wr_en;
  assign flag_zero    = r_zero;
  assign flag_carry   = r_carry;
  assign flag_dz      = r_dz;
  assign flag_illegal = r_ill;

endmodule

// File: tb/tb_alu_execute_unit.sv
`timescale 1ns/1ps
module tb_alu_execute_unit;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] alu_sel;
  logic [1:0] alu_b_sel;
  logic [3:0] destination_reg_flag;
  logic [7:0] reg_a, reg_b, reg_c, reg_d;
  logic [7:0] result, result_hi;
  logic       busy, done;
  logic [3:0] wr_en;
  logic       flag_zero, flag_carry, flag_dz, flag_illegal;

  always #5 clk = ~clk;

  alu_execute_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .alu_sel(alu_sel), .alu_b_sel(alu_b_sel),
    .destination_reg_flag(destination_reg_flag),
    .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .reg_d(reg_d),
    .result(result), .result_hi(result_hi),
    .busy(busy), .done(done), .wr_en(wr_en),
    .flag_zero(flag_zero), .flag_carry(flag_carry),
    .flag_dz(flag_dz), .flag_illegal(flag_illegal)
  );

`ifdef ALU_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 9;
`endif

  typedef struct {
    logic [2:0] sel;
    logic [1:0] bsel;
    logic [3:0] dest;
    logic [7:0] a, b, c, d;
    logic [7:0] res, hi;
    logic       carry, zero, dz, ill;
    logic [3:0] wr;
    int         lat;
  } vec_t;

  vec_t vecs[16];
  vec_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic [2:0] sel, logic [1:0] bsel, logic [3:0] dest,
                              logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d,
                              logic [7:0] res, logic [7:0] hi, logic carry, logic zero,
                              logic dz, logic ill, logic [3:0] wr, int lat);
    vec_t v;
    v.sel = sel; v.bsel = bsel; v.dest = dest;
    v.a = a; v.b = b; v.c = c; v.d = d;
    v.res = res; v.hi = hi; v.carry = carry; v.zero = zero;
    v.dz = dz; v.ill = ill; v.wr = wr; v.lat = lat;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic launch(vec_t v, bit hold);
    @(negedge clk);
    alu_sel = v.sel; alu_b_sel = v.bsel; destination_reg_flag = v.dest;
    reg_a = v.a; reg_b = v.b; reg_c = v.c; reg_d = v.d;
    start = 1'b1;
    @(posedge clk); #1;
    sbq.push_back(v);
    if (!hold) start = 1'b0;
    // operands must already be latched; scramble the register file
    reg_a = 8'($urandom); reg_b = 8'($urandom); reg_c = 8'($urandom); reg_d = 8'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("result_cleared_on_start", result, 0);
  endtask

  task automatic wait_done(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n; ok = 1'b1;
        break;
      end
      chk("busy_while_running", busy, 1);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_40");
    end
  endtask

  task automatic check_done(int lat);
    vec_t e;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty actual=done required=no_done");
      return;
    end
    e = sbq.pop_front();
    chk("latency", lat, e.lat);
    chk("result", result, e.res);
    chk("result_hi", result_hi, e.hi);
    chk("flag_carry", flag_carry, e.carry);
    chk("flag_zero", flag_zero, e.zero);
    chk("flag_dz", flag_dz, e.dz);
    chk("flag_illegal", flag_illegal, e.ill);
    chk("wr_en", wr_en, e.wr);
    chk("busy_at_done", busy, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("wr_en_one_cycle", wr_en, 0);
    chk("result_held", result, e.res);
    chk("result_hi_held", result_hi, e.hi);
  endtask

  task automatic run(vec_t v);
    int lat; bit ok;
    launch(v, 1'b0);
    wait_done(lat, ok);
    if (ok) check_done(lat);
  endtask

  initial begin
    int  npulse;
    int  lat;
    bit  ok;

    //            sel     bsel   dest     a      b      c      d      res    hi    c  z  dz il wr       lat
    vecs[0]  = mk(3'b000, 2'b10, 4'b0001, 8'h0F, 8'h00, 8'h01, 8'h00, 8'h10, 8'h00, 0, 0, 0, 0, 4'b0001, 1);
    vecs[1]  = mk(3'b001, 2'b01, 4'b0010, 8'h10, 8'h20, 8'h00, 8'h00, 8'hF0, 8'h00, 1, 0, 0, 0, 4'b0010, 1);
    vecs[2]  = mk(3'b010, 2'b11, 4'b0100, 8'h12, 8'h00, 8'h00, 8'h34, 8'hA8, 8'h03, 1, 0, 0, 0, 4'b0100, ML);
    vecs[3]  = mk(3'b011, 2'b01, 4'b1000, 8'hC8, 8'h07, 8'h00, 8'h00, 8'h1C, 8'h04, 0, 0, 0, 0, 4'b1000, 9);
    vecs[4]  = mk(3'b011, 2'b01, 4'b0001, 8'hC8, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hC8, 0, 0, 1, 0, 4'b0001, 1);
    vecs[5]  = mk(3'b101, 2'b01, 4'b0100, 8'h33, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1, 4'b0000, 1);
    vecs[6]  = mk(3'b000, 2'b01, 4'b0010, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 4'b0010, 1);
    vecs[7]  = mk(3'b001, 2'b10, 4'b1000, 8'h00, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00, 1, 0, 0, 0, 4'b1000, 1);
    vecs[8]  = mk(3'b000, 2'b00, 4'b0001, 8'h55, 8'hAA, 8'hBB, 8'hCC, 8'h55, 8'h00, 0, 0, 0, 0, 4'b0001, 1);
    vecs[9]  = mk(3'b010, 2'b01, 4'b0010, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'hFE, 1, 0, 0, 0, 4'b0010, ML);
    vecs[10] = mk(3'b010, 2'b10, 4'b0100, 8'h00, 8'h00, 8'h37, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 4'b0100, ML);
    vecs[11] = mk(3'b011, 2'b11, 4'b1000, 8'hFF, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h00, 0, 0, 0, 0, 4'b1000, 9);
    vecs[12] = mk(3'b011, 2'b10, 4'b0001, 8'h05, 8'h00, 8'h09, 8'h00, 8'h00, 8'h05, 0, 1, 0, 0, 4'b0001, 9);
    vecs[13] = mk(3'b010, 2'b01, 4'b0010, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 1, 1, 0, 0, 4'b0010, ML);
    vecs[14] = mk(3'b111, 2'b00, 4'b1111, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1, 4'b0000, 1);
    vecs[15] = mk(3'b001, 2'b11, 4'b0100, 8'h7E, 8'h00, 8'h00, 8'h7E, 8'h00, 8'h00, 0, 1, 0, 0, 4'b0100, 1);

    rst = 1'b1; start = 1'b0; alu_sel = '0; alu_b_sel = '0; destination_reg_flag = '0;
    reg_a = '0; reg_b = '0; reg_c = '0; reg_d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", result, 0);
    chk("reset_result_hi", result_hi, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_flags", {flag_zero, flag_carry, flag_dz, flag_illegal}, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 16; i++) run(vecs[i]);

    // reset in the middle of a MUL: abort with no done/wr_en
    launch(vecs[2], 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    sbq.delete();
    chk("abort_result", result, 0);
    chk("abort_result_hi", result_hi, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_flags", {flag_zero, flag_carry, flag_dz, flag_illegal}, 0);
    rst = 1'b0;
    npulse = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done || (wr_en != 0) || busy) npulse++;
    end
    chk("abort_no_activity", npulse, 0);
    run(vecs[0]);

    // start held high for the whole DIV, including the DONE cycle
    launch(vecs[3], 1'b1);
    wait_done(lat, ok);
    if (ok) check_done(lat);
    start = 1'b0;
    npulse = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done || busy) npulse++;
    end
    chk("held_start_single_done", npulse, 0);
    chk("held_start_result_kept", result, 8'h1C);

    // back-to-back after the held-start case
    run(vecs[5]);
    run(vecs[9]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
